// File: rtl/ldst_pipe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ldst_pipe_scheduler
// Purpose  : Arbitrates one load/store pipe between the execution unit (EXE)
//            and the exception unit (EXC). Exception requests take priority.
//            An exception that arrives while EXE owns the pipe waits in DRAIN
//            until every EXE transaction has been answered. Responses go back
//            to the most recently granted owner.
// Ports    : iCLOCK, iRESET_SYNC           - clock, synchronous active-high reset
//            iEXE_* / oEXE_*               - execution-unit request/response
//            iEXCEPT_* / oEXCEPT_*         - exception-unit request/response
//            oLDST_* / iLDST_*             - load/store pipe side
//            oOWNER                        - 00 IDLE, 01 EXE, 10 EXC, 11 DRAIN
//            oPROTOCOL_ERR                 - sticky: VALID seen with nothing outstanding
//            oTIMEOUT                      - sticky watchdog flag
// Options  : LDST_PIPE_SCHED_TIMEOUT_EN    - enables the 8-bit response watchdog
// Revision : 1.0 - initial release
// ============================================================================
module ldst_pipe_scheduler #(
    parameter int P_MAX_OUTSTANDING = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iEXE_REQ,
    output logic        oEXE_BUSY,
    input  logic [1:0]  iEXE_ORDER,
    input  logic [3:0]  iEXE_MASK,
    input  logic [0:0]  iEXE_RW,
    input  logic [31:0] iEXE_ADDR,
    input  logic [31:0] iEXE_DATA,
    output logic        oEXE_VALID,
    output logic [31:0] oEXE_DATA,
    input  logic        iEXCEPT_REQ,
    output logic        oEXCEPT_BUSY,
    input  logic [1:0]  iEXCEPT_ORDER,
    input  logic [0:0]  iEXCEPT_RW,
    input  logic [31:0] iEXCEPT_ADDR,
    input  logic [31:0] iEXCEPT_DATA,
    output logic        oEXCEPT_VALID,
    output logic [31:0] oEXCEPT_DATA,
    output logic        oLDST_REQ,
    input  logic        iLDST_BUSY,
    output logic [1:0]  oLDST_ORDER,
    output logic [3:0]  oLDST_MASK,
    output logic [0:0]  oLDST_RW,
    output logic [31:0] oLDST_ADDR,
    output logic [31:0] oLDST_DATA,
    input  logic        iLDST_VALID,
    input  logic [31:0] iLDST_DATA,
    output logic [1:0]  oOWNER,
    output logic        oPROTOCOL_ERR,
    output logic        oTIMEOUT
);

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_EXE   = 2'b01;
    localparam logic [1:0] c_ST_EXC   = 2'b10;
    localparam logic [1:0] c_ST_DRAIN = 2'b11;
    localparam logic       c_OWN_EXE  = 1'b0;
    localparam logic       c_OWN_EXC  = 1'b1;
    localparam logic [2:0] c_MAX      = 3'(P_MAX_OUTSTANDING);

    logic [1:0]  r_state, w_state_next;
    logic [1:0]  r_target, w_target_next;
    logic        r_resp_owner, w_resp_owner_next;
    logic [2:0]  r_count;
    logic        r_protocol_err;
    logic        w_full, w_zero, w_accept, w_valid_ok;
    logic        w_ldst_req, w_exe_busy, w_exc_busy;

    assign w_full = (r_count == c_MAX);
    assign w_zero = (r_count == 3'd0);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state      <= c_ST_IDLE;
            r_target     <= c_ST_EXC;
            r_resp_owner <= c_OWN_EXE;
        end else begin
            r_state      <= w_state_next;
            r_target     <= w_target_next;
            r_resp_owner <= w_resp_owner_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_target_next     = r_target;
        w_resp_owner_next = r_resp_owner;
        w_ldst_req        = 1'b0;
        w_exe_busy        = 1'b1;
        w_exc_busy        = 1'b1;
        oLDST_ORDER       = 2'b00;
        oLDST_MASK        = 4'h0;
        oLDST_RW          = 1'b0;
        oLDST_ADDR        = 32'h0;
        oLDST_DATA        = 32'h0;
        case (r_state)
            c_ST_IDLE: begin
                if (iEXCEPT_REQ) begin
                    w_state_next      = c_ST_EXC;
                    w_resp_owner_next = c_OWN_EXC;
                end else if (iEXE_REQ) begin
                    w_state_next      = c_ST_EXE;
                    w_resp_owner_next = c_OWN_EXE;
                end
            end
            c_ST_EXE: begin
                oLDST_ORDER = iEXE_ORDER;
                oLDST_MASK  = iEXE_MASK;
                oLDST_RW    = iEXE_RW;
                oLDST_ADDR  = iEXE_ADDR;
                oLDST_DATA  = iEXE_DATA;
                if (iEXCEPT_REQ) begin
                    // Stop issuing immediately; EXE is held busy by the default.
                    w_state_next  = c_ST_DRAIN;
                    w_target_next = c_ST_EXC;
                end else begin
                    w_ldst_req = iEXE_REQ & ~w_full;
                    w_exe_busy = iLDST_BUSY | w_full;
                    if (!iEXE_REQ && w_zero) begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            c_ST_EXC: begin
                oLDST_ORDER = iEXCEPT_ORDER;
                oLDST_MASK  = 4'hf;
                oLDST_RW    = iEXCEPT_RW;
                oLDST_ADDR  = iEXCEPT_ADDR;
                oLDST_DATA  = iEXCEPT_DATA;
                w_ldst_req  = iEXCEPT_REQ & ~w_full;
                w_exc_busy  = iLDST_BUSY | w_full;
                if (!iEXCEPT_REQ && w_zero) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                // DRAIN: the response owner stays put until the handover.
                if (w_zero) begin
                    w_state_next      = r_target;
                    w_resp_owner_next = (r_target == c_ST_EXC) ? c_OWN_EXC : c_OWN_EXE;
                end
            end
        endcase
        // Outputs are forced to their idle values while reset is asserted.
        if (iRESET_SYNC) begin
            w_ldst_req = 1'b0;
            w_exe_busy = 1'b1;
            w_exc_busy = 1'b1;
        end
    end

    assign w_accept   = w_ldst_req & ~iLDST_BUSY;
    // A VALID with nothing outstanding is dropped so the count cannot underflow.
    assign w_valid_ok = iLDST_VALID & ~w_zero & ~iRESET_SYNC;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_count        <= 3'd0;
            r_protocol_err <= 1'b0;
        end else begin
            r_count        <= r_count + {2'b00, w_accept} - {2'b00, w_valid_ok};
            r_protocol_err <= r_protocol_err | (iLDST_VALID & w_zero);
        end
    end

    assign oLDST_REQ     = w_ldst_req;
    assign oEXE_BUSY     = w_exe_busy;
    assign oEXCEPT_BUSY  = w_exc_busy;
    assign oEXE_VALID    = w_valid_ok & (r_resp_owner == c_OWN_EXE);
    assign oEXCEPT_VALID = w_valid_ok & (r_resp_owner == c_OWN_EXC);
    assign oEXE_DATA     = oEXE_VALID ? iLDST_DATA : 32'h0;
    assign oEXCEPT_DATA  = oEXCEPT_VALID ? iLDST_DATA : 32'h0;
    assign oOWNER        = iRESET_SYNC ? c_ST_IDLE : r_state;
    assign oPROTOCOL_ERR = r_protocol_err;

`ifdef LDST_PIPE_SCHED_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_timeout;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_wdog    <= 8'd0;
            r_timeout <= 1'b0;
        end else if (!w_zero && !iLDST_VALID) begin
            if (r_wdog != 8'hff) begin
                r_wdog <= r_wdog + 8'd1;
            end
            if (r_wdog >= 8'hfe) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wdog <= 8'd0;
        end
    end

    assign oTIMEOUT = r_timeout;
`else
    assign oTIMEOUT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ldst_pipe_scheduler.md
LDST_PIPE_SCHEDULER -- requirements
Module: ldst_pipe_scheduler

Interface
REQ-001 SHALL have parameter P_MAX_OUTSTANDING, default 4, giving the maximum accepted-but-unanswered load/store transactions (legal values 1..7).
REQ-002 SHALL have port iCLOCK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRESET_SYNC, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have ports iEXE_REQ/iEXCEPT_REQ, input, 1 bit each: requests from the execution unit and the exception unit.
REQ-005 SHALL have ports iEXE_ORDER/iEXCEPT_ORDER [1:0], iEXE_MASK [3:0], iEXE_RW/iEXCEPT_RW [0:0], iEXE_ADDR/iEXCEPT_ADDR [31:0] and iEXE_DATA/iEXCEPT_DATA [31:0], all inputs: request fields.
REQ-006 SHALL have ports oEXE_BUSY/oEXCEPT_BUSY, output, 1 bit each: the requester must hold its request.
REQ-007 SHALL have ports oEXE_VALID/oEXCEPT_VALID, output, 1 bit each, and oEXE_DATA/oEXCEPT_DATA, output, 32 bits each: response routing.
REQ-008 SHALL have pipe-side ports oLDST_REQ (output, 1), iLDST_BUSY (input, 1), oLDST_ORDER (output, 2), oLDST_MASK (output, 4), oLDST_RW (output, 1), oLDST_ADDR (output, 32), oLDST_DATA (output, 32), iLDST_VALID (input, 1) and iLDST_DATA (input, 32).
REQ-009 SHALL have ports oOWNER, output, 2 bits (00 IDLE, 01 EXE, 10 EXC, 11 DRAIN); oPROTOCOL_ERR, output, 1 bit; and oTIMEOUT, output, 1 bit.

Function
REQ-010 SHALL implement FSM states IDLE, EXE, EXC and DRAIN, with registered target and response-owner registers.
REQ-011 SHALL, in IDLE, forward nothing; when iEXCEPT_REQ is high it SHALL go to EXC, otherwise when iEXE_REQ is high it SHALL go to EXE; exception wins on simultaneous requests; grant latency SHALL be 1 cycle.
REQ-012 SHALL, in EXE, mux EXE fields onto the pipe, drive oLDST_REQ=iEXE_REQ and drive oEXE_BUSY=iLDST_BUSY.
REQ-013 SHALL, in EXC, mux EXCEPT fields onto the pipe, drive oLDST_MASK=4'hf and drive oEXCEPT_BUSY=iLDST_BUSY.
REQ-014 SHALL, when in EXE and iEXCEPT_REQ is high, suppress oLDST_REQ and assert oEXE_BUSY in that same cycle, then go to DRAIN with target EXC.
REQ-015 SHALL, in DRAIN, drive oLDST_REQ=0 and assert both BUSY outputs, and SHALL go to the target state in the cycle after the outstanding count reaches 0.
REQ-016 SHALL leave EXE for IDLE when iEXE_REQ=0 and outstanding=0, and SHALL leave EXC for IDLE when iEXCEPT_REQ=0 and outstanding=0.
REQ-017 SHALL hold BUSY at 1 for the non-owner in every state.
REQ-018 SHALL define accept as oLDST_REQ & ~iLDST_BUSY, and SHALL update the outstanding count each cycle as count + accept - iLDST_VALID, with width 3 bits.
REQ-019 SHALL, when the count equals P_MAX_OUTSTANDING, force oLDST_REQ=0 and assert the owner's BUSY; an accept and a VALID in the same cycle SHALL leave the count unchanged.
REQ-020 SHALL route iLDST_VALID/iLDST_DATA to the response owner only, which is the last granted owner and persists through DRAIN; the other VALID output SHALL be 0.
REQ-021 SHALL treat iLDST_VALID with count 0 as a protocol error: the response is not routed, the count does not underflow, and oPROTOCOL_ERR is set sticky.

Reset
REQ-022 SHALL, on iRESET_SYNC=1 at a clock edge, clear FSM state to IDLE, the outstanding count to 0, the response owner to EXE, and oPROTOCOL_ERR and oTIMEOUT to 0, regardless of any transaction in flight.
REQ-023 SHALL output, during and after reset, oLDST_REQ=0, both BUSY=1, both VALID=0 and oOWNER=00.
REQ-024 SHALL ignore, after a mid-operation reset, any late iLDST_VALID for pre-reset transactions, and SHALL flag each such VALID per REQ-021.

Configuration
REQ-025 SHALL include, with macro LDST_PIPE_SCHED_TIMEOUT_EN defined, an 8-bit watchdog that increments each cycle while count != 0 and iLDST_VALID = 0, clears otherwise, and sets oTIMEOUT sticky on reaching 255.
REQ-026 SHALL, with LDST_PIPE_SCHED_TIMEOUT_EN undefined, omit the watchdog and tie oTIMEOUT to 0; the port SHALL remain present.

Verification
REQ-027 SHALL cover: iEXE_REQ=1, ADDR=0x1000, pipe idle -> oOWNER=01 after 1 cycle, oLDST_ADDR=0x1000, oLDST_REQ=1.
REQ-028 SHALL cover: both requests high in IDLE -> EXC granted, oLDST_MASK=4'hf, oEXE_BUSY=1.
REQ-029 SHALL cover: EXE owner with 2 outstanding, then iEXCEPT_REQ=1 -> DRAIN; no oLDST_REQ until both VALIDs arrive on oEXE_VALID; EXC granted on the next cycle.
REQ-030 SHALL cover: 4 accepts with no VALID -> oLDST_REQ=0 and owner BUSY=1; one VALID -> next request accepted.
REQ-031 SHALL cover: iLDST_VALID with count 0 -> no VALID output and oPROTOCOL_ERR=1 until reset.
REQ-032 SHALL cover, with TIMEOUT_EN defined: 1 outstanding and no VALID for 255 cycles -> oTIMEOUT=1; with the macro undefined, oTIMEOUT stays 0.
